// File: rtl/m68k_bus_pkg.sv
// Shared types for the 68000 bus-cycle responder: FSM states, region classes and counter widths.
package m68k_bus_pkg;

  localparam int TIMEOUT_W = 8;
  localparam int WAITS_W   = 4;

  typedef enum logic [1:0] {IDLE, WAIT, ACK, BERR} bus_state_e;

  typedef enum logic [2:0] {
    CLS_ROM, CLS_SHARED, CLS_RAM, CLS_PAL, CLS_REG, CLS_NONE
  } region_cls_e;

  // Fixed priority: prog_rom > shared_ram > ram > pal > reg > none.
  function automatic region_cls_e classify(input logic rom, input logic shared,
                                           input logic ram, input logic pal,
                                           input logic reg_sel);
    region_cls_e cls;
    if (rom)          cls = CLS_ROM;
    else if (shared)  cls = CLS_SHARED;
    else if (ram)     cls = CLS_RAM;
    else if (pal)     cls = CLS_PAL;
    else if (reg_sel) cls = CLS_REG;
    else              cls = CLS_NONE;
    return cls;
  endfunction

  function automatic logic [WAITS_W-1:0] initial_waits(input region_cls_e cls,
                                                      input logic [WAITS_W-1:0] pal_waits,
                                                      input logic [WAITS_W-1:0] reg_waits);
    logic [WAITS_W-1:0] waits;
    case (cls)
      CLS_PAL: waits = pal_waits;
      CLS_REG: waits = reg_waits;
      default: waits = '0;
    endcase
    return waits;
  endfunction

endpackage

// File: rtl/bus_timeout_counter.sv
// Counts WAIT cycles of one bus cycle and flags when the count has reached the limit.
module bus_timeout_counter
  import m68k_bus_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clear,
  input  logic                 enable,
  input  logic [TIMEOUT_W-1:0] limit,
  output logic                 expired
);

  logic [TIMEOUT_W-1:0] count_q, count_d;

  // Holding at the limit keeps the count from ever wrapping back below it.
  always_comb begin
    count_d = count_q;
    if (clear)
      count_d = '0;
    else if (enable && (count_q != limit))
      count_d = count_q + TIMEOUT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) count_q <= '0;
    else       count_q <= count_d;
  end

  assign expired = (count_q == limit);

endmodule

// File: rtl/m68k_dtack_gen.sv
// 68000 DTACK/BERR responder with per-region wait states and handshakes.
// Define DTACK_TIMEOUT_EN to build the WAIT timeout that ends stalled cycles in BERR.
module m68k_dtack_gen
  import m68k_bus_pkg::*;
#(
  parameter int unsigned PAL_WAITS = 1,
  parameter int unsigned REG_WAITS = 0,
  parameter int unsigned TIMEOUT   = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic cpu_as_n,
  input  logic prog_rom_cs,
  input  logic prog_rom_ready,
  input  logic ram_cs,
  input  logic shared_ram_cs,
  input  logic z80_shared_busy,
  input  logic pal_cs,
  input  logic reg_cs,
  output logic cpu_dtack_n,
  output logic cpu_berr_n,
  output logic busy
);

  if (PAL_WAITS > 15) begin : g_bad_pal_waits
    $error("PAL_WAITS must be in 0..15");
  end
  if (REG_WAITS > 15) begin : g_bad_reg_waits
    $error("REG_WAITS must be in 0..15");
  end
  if ((TIMEOUT < 1) || (TIMEOUT > 255)) begin : g_bad_timeout
    $error("TIMEOUT must be in 1..255");
  end

  localparam logic [WAITS_W-1:0] PAL_WAITS_L = WAITS_W'(PAL_WAITS);
  localparam logic [WAITS_W-1:0] REG_WAITS_L = WAITS_W'(REG_WAITS);

  bus_state_e          state_q, state_d;
  region_cls_e         cls_q, cls_d;
  logic [WAITS_W-1:0]  wait_cnt_q, wait_cnt_d;
  logic                armed_q, armed_d;
  logic                dtack_n_q, dtack_n_d;
  logic                busy_q, busy_d;
  logic                cycle_start;
  logic                class_ready;
  logic                in_wait;
  logic                timeout_expired;

  assign cycle_start = (state_q == IDLE) && armed_q && !cpu_as_n;
  assign in_wait     = (state_q == WAIT);

  always_comb begin
    class_ready = 1'b0;
    case (cls_q)
      CLS_RAM, CLS_PAL, CLS_REG: class_ready = (wait_cnt_q == '0);
      CLS_ROM:                   class_ready = prog_rom_ready;
      CLS_SHARED:                class_ready = !z80_shared_busy;
`ifdef DTACK_TIMEOUT_EN
      CLS_NONE:                  class_ready = 1'b0;
`else
      // Unmapped accesses complete as open-bus reads with no wait states.
      CLS_NONE:                  class_ready = (wait_cnt_q == '0);
`endif
      default:                   class_ready = 1'b0;
    endcase
  end

  // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d    = state_q;
    cls_d      = cls_q;
    wait_cnt_d = wait_cnt_q;
    armed_d    = armed_q;

    if (cpu_as_n)         armed_d = 1'b1;
    else if (cycle_start) armed_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (cycle_start) begin
          state_d    = WAIT;
          cls_d      = classify(prog_rom_cs, shared_ram_cs, ram_cs, pal_cs, reg_cs);
          wait_cnt_d = initial_waits(cls_d, PAL_WAITS_L, REG_WAITS_L);
        end
      end
      WAIT: begin
        // Abort beats ready, and ready beats timeout.
        if (cpu_as_n)
          state_d = IDLE;
        else if (class_ready)
          state_d = ACK;
        else if (timeout_expired)
          state_d = BERR;
        else if (wait_cnt_q != '0)
          wait_cnt_d = wait_cnt_q - WAITS_W'(1);
      end
      ACK, BERR: begin
        if (cpu_as_n) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    dtack_n_d = (state_q != ACK);
    busy_d    = (state_d == WAIT);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      cls_q      <= CLS_NONE;
      wait_cnt_q <= '0;
      armed_q    <= 1'b0;
      dtack_n_q  <= 1'b1;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cls_q      <= cls_d;
      wait_cnt_q <= wait_cnt_d;
      armed_q    <= armed_d;
      dtack_n_q  <= dtack_n_d;
      busy_q     <= busy_d;
    end
  end

`ifdef DTACK_TIMEOUT_EN
  localparam logic [TIMEOUT_W-1:0] TIMEOUT_L = TIMEOUT_W'(TIMEOUT);

  logic berr_n_q, berr_n_d;

  bus_timeout_counter u_timeout (
    .clk     (clk),
    .reset   (reset),
    .clear   (cycle_start),
    .enable  (in_wait),
    .limit   (TIMEOUT_L),
    .expired (timeout_expired)
  );

  always_comb berr_n_d = (state_q != BERR);

  always_ff @(posedge clk) begin
    if (reset) berr_n_q <= 1'b1;
    else       berr_n_q <= berr_n_d;
  end

  assign cpu_berr_n = berr_n_q;
`else
  assign timeout_expired = 1'b0;
  assign cpu_berr_n      = 1'b1;
  logic unused_in_wait;
  assign unused_in_wait  = in_wait;
`endif

  assign cpu_dtack_n = dtack_n_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_m68k_dtack_gen.sv
// Self-checking bench for m68k_dtack_gen: directed vector table, hand sequences, randomized cycles.
module tb_m68k_dtack_gen;

  localparam int PAL_W = 3;
  localparam int REG_W = 2;
  localparam int TMO   = 16;

  logic clk = 1'b0;
  logic reset;
  logic cpu_as_n;
  logic prog_rom_cs, prog_rom_ready, ram_cs, shared_ram_cs, z80_shared_busy, pal_cs, reg_cs;
  logic cpu_dtack_n, cpu_berr_n, busy;

  int tests = 0;
  int fails = 0;

  m68k_dtack_gen #(
    .PAL_WAITS (PAL_W),
    .REG_WAITS (REG_W),
    .TIMEOUT   (TMO)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .cpu_as_n        (cpu_as_n),
    .prog_rom_cs     (prog_rom_cs),
    .prog_rom_ready  (prog_rom_ready),
    .ram_cs          (ram_cs),
    .shared_ram_cs   (shared_ram_cs),
    .z80_shared_busy (z80_shared_busy),
    .pal_cs          (pal_cs),
    .reg_cs          (reg_cs),
    .cpu_dtack_n     (cpu_dtack_n),
    .cpu_berr_n      (cpu_berr_n),
    .busy            (busy)
  );

  always #5 clk = ~clk;

  // cs bit order: {prog_rom, shared_ram, ram, pal, reg}.
  // e: edge index (0 = edge that samples cpu_as_n low) at which the cycle leaves WAIT.
  typedef struct {
    logic [4:0] cs;
    int         r;
    bit         pulse;
    int         hold;
    int         gap;
    int         e;
    bit         berr;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [2:0] act, input logic [2:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: {dtack_n,berr_n,busy} got %b expected %b", name, act, exp);
    end
  endtask

  task automatic drive(input bit as_n, input logic [4:0] cs, input bit rdy);
    cpu_as_n        = as_n;
    prog_rom_cs     = cs[4];
    shared_ram_cs   = cs[3];
    ram_cs          = cs[2];
    pal_cs          = cs[1];
    reg_cs          = cs[0];
    prog_rom_ready  = rdy;
    z80_shared_busy = !rdy;
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Strobe low for `hold` sampled edges, then high for `gap`. Ready (and !z80 busy)
  // is high from edge r onward, or only at edge r when pulse is set.
  task automatic run_txn(input string name, input logic [4:0] cs, input int r, input bit pulse,
                         input int hold, input int gap, input int e, input bit berr);
    bit abort, low, rdy;
    logic [2:0] exp;
    abort = (hold <= e);
    for (int t = 0; t < hold + gap; t++) begin
      low = (t < hold);
      rdy = pulse ? (t == r) : (t >= r);
      drive(!low, low ? cs : 5'b00000, rdy);
      tick();
      exp = 3'b110;
      if (t < (abort ? hold : e)) exp[0] = 1'b1;
      if (!abort && (t > e) && (t <= hold)) begin
        if (berr) exp[1] = 1'b0;
        else      exp[2] = 1'b0;
      end
      check($sformatf("%s t=%0d", name, t), {cpu_dtack_n, cpu_berr_n, busy}, exp);
    end
  endtask

  // Reference timing from the region rules: counted regions leave WAIT after their
  // wait count, handshake regions on the first WAIT edge that sees ready.
  function automatic void model(input logic [4:0] cs, input int r, output int e, output bit berr);
    berr = 1'b0;
    if (cs[4] || cs[3]) e = (r < 1) ? 1 : r;
    else if (cs[2])     e = 1;
    else if (cs[1])     e = 1 + PAL_W;
    else if (cs[0])     e = 1 + REG_W;
    else begin
`ifdef DTACK_TIMEOUT_EN
      e    = TMO + 1;
      berr = 1'b1;
`else
      e    = 1;
`endif
    end
`ifdef DTACK_TIMEOUT_EN
    if (e > TMO + 1) begin
      e    = TMO + 1;
      berr = 1'b1;
    end
`endif
  endfunction

  initial begin
    logic [4:0] rcs;
    int r, hold, gap, e;
    bit berr;

    vecs.push_back('{5'b00100, 0, 1'b0, 5, 2, 1, 1'b0});    // ram
    vecs.push_back('{5'b00010, 0, 1'b0, 8, 2, 4, 1'b0});    // palette, 3 waits
    vecs.push_back('{5'b00001, 0, 1'b0, 6, 1, 3, 1'b0});    // register, 2 waits
    vecs.push_back('{5'b10000, 11, 1'b0, 14, 1, 11, 1'b0}); // rom, ready held from 11
    vecs.push_back('{5'b10000, 10, 1'b1, 14, 2, 10, 1'b0}); // rom, one-cycle ready pulse
`ifdef DTACK_TIMEOUT_EN
    vecs.push_back('{5'b01000, 20, 1'b0, 15, 2, 17, 1'b1}); // shared, z80 busy, aborted
`else
    vecs.push_back('{5'b01000, 20, 1'b0, 15, 2, 20, 1'b0});
`endif
    vecs.push_back('{5'b01000, 0, 1'b0, 4, 1, 1, 1'b0});    // shared, free
    vecs.push_back('{5'b10100, 4, 1'b0, 7, 1, 4, 1'b0});    // rom beats ram
    vecs.push_back('{5'b01010, 3, 1'b0, 6, 1, 3, 1'b0});    // shared beats pal
    vecs.push_back('{5'b00111, 0, 1'b0, 3, 1, 1, 1'b0});    // ram beats pal/reg
    vecs.push_back('{5'b00011, 0, 1'b0, 6, 1, 4, 1'b0});    // pal beats reg
    vecs.push_back('{5'b00010, 0, 1'b0, 3, 1, 4, 1'b0});    // pal aborted mid-wait
    vecs.push_back('{5'b00100, 0, 1'b0, 1, 2, 1, 1'b0});    // strobe high with ready: abort
    vecs.push_back('{5'b00100, 0, 1'b0, 2, 1, 1, 1'b0});    // shortest acknowledged strobe
`ifdef DTACK_TIMEOUT_EN
    vecs.push_back('{5'b00000, 0, 1'b0, 20, 2, 17, 1'b1});  // unmapped -> BERR
    vecs.push_back('{5'b10000, 17, 1'b0, 20, 1, 17, 1'b0}); // ready with timeout: ACK wins
    vecs.push_back('{5'b10000, 18, 1'b0, 21, 1, 17, 1'b1}); // ready one edge late: BERR
`else
    vecs.push_back('{5'b00000, 0, 1'b0, 4, 1, 1, 1'b0});    // unmapped acks as ram
    vecs.push_back('{5'b10000, 17, 1'b0, 20, 1, 17, 1'b0});
    vecs.push_back('{5'b10000, 18, 1'b0, 21, 1, 18, 1'b0});
`endif

    reset = 1'b1;
    drive(1'b1, 5'b00000, 1'b0);
    tick();
    tick();
    check("reset values", {cpu_dtack_n, cpu_berr_n, busy}, 3'b110);
    reset = 1'b0;
    tick();
    check("idle after reset", {cpu_dtack_n, cpu_berr_n, busy}, 3'b110);

    for (int i = 0; i < vecs.size(); i++)
      run_txn($sformatf("vec%0d", i), vecs[i].cs, vecs[i].r, vecs[i].pulse,
              vecs[i].hold, vecs[i].gap, vecs[i].e, vecs[i].berr);

    // Reset in the middle of a palette wait, strobe kept low afterwards.
    drive(1'b0, 5'b00010, 1'b0);
    tick();
    check("pre-reset wait 0", {cpu_dtack_n, cpu_berr_n, busy}, 3'b111);
    tick();
    check("pre-reset wait 1", {cpu_dtack_n, cpu_berr_n, busy}, 3'b111);
    reset = 1'b1;
    tick();
    check("reset mid-wait", {cpu_dtack_n, cpu_berr_n, busy}, 3'b110);
    reset = 1'b0;
    for (int t = 0; t < 8; t++) begin
      tick();
      check($sformatf("held strobe after reset t=%0d", t), {cpu_dtack_n, cpu_berr_n, busy}, 3'b110);
    end
    drive(1'b1, 5'b00000, 1'b0);
    tick();
    check("strobe released", {cpu_dtack_n, cpu_berr_n, busy}, 3'b110);
    run_txn("post-reset ram", 5'b00100, 0, 1'b0, 3, 2, 1, 1'b0);

    for (int n = 0; n < 150; n++) begin
      rcs  = 5'($urandom_range(0, 31));
      r    = int'($urandom_range(0, 22));
      hold = int'($urandom_range(1, 24));
      gap  = int'($urandom_range(1, 3));
      model(rcs, r, e, berr);
      run_txn($sformatf("rnd%0d cs=%b r=%0d hold=%0d", n, rcs, r, hold), rcs, r, 1'b0,
              hold, gap, e, berr);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
